twiddle_mul_16bundle: RTL
=========================

TWIDDLE_MUL_16BUNDLE -- requirements
Module: twiddle_mul_16bundle

Interface
REQ-001 Parameters: IN_WIDTH, default 10, lane input width; OUT_WIDTH, default 10, lane output width; TW_WIDTH, default 9, signed twiddle width; LANES, default 16; BLOCKS, default 32, bundles per 512-point frame.
REQ-002 Clocking: one clock; reset is synchronous and active-high.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 in_valid  in  1  din bundle valid this cycle.
REQ-006 in_sof  in  1  start of frame; qualified by in_valid.
REQ-007 din_R, din_Q  in  signed IN_WIDTH x LANES  real/imag bundle from upstream butterfly stage.
REQ-008 sat_clr  in  1  clears sat_flag.
REQ-009 out_valid  out  1  dout bundle valid.
REQ-010 out_sof  out  1  first bundle of frame at output.
REQ-011 out_blk  out  log2(BLOCKS)  block index of dout bundle.
REQ-012 dout_R, dout_Q  out  signed OUT_WIDTH x LANES  twiddled bundle.
REQ-013 sat_flag  out  1  sticky, set when any lane saturates.

Function
REQ-014 Sample index n = blk*LANES + lane; q = {0,2,1,3}[n div 128]; e = (n mod 128)*q; twiddle = (round(128*cos(2*pi*e/512)), -round(128*sin(2*pi*e/512))), Q2.7.
REQ-015 Per lane: re = a*c - b*d, im = a*d + b*c, full precision; then add 64, arithmetic shift right 7; then saturate to OUT_WIDTH signed range.
REQ-016 Latency: exactly 3 cycles, in_valid at cycle t gives out_valid at t+3.
REQ-017 Pipeline: S1 registers din, block index and ROM twiddle; S2 registers four products per lane; S3 registers round/saturate result.
REQ-018 No backpressure: every in_valid bundle is accepted and emerges; gaps in in_valid propagate as gaps in out_valid.
REQ-019 Block counter advances by 1 per accepted bundle; it wraps BLOCKS-1 -> 0.
REQ-020 in_valid with in_sof: that bundle uses block 0; counter becomes 1. in_sof without in_valid is ignored.
REQ-021 out_sof, out_blk travel with their bundle through the pipeline.
REQ-022 When out_valid=0, dout_R/dout_Q hold their last values.
REQ-023 sat_flag sets on the S3 cycle of any saturation. sat_clr clears it. Simultaneous clear and new saturation leaves sat_flag=1.

Reset
REQ-024 rst: out_valid, out_sof, sat_flag, out_blk, all dout lanes, pipeline valids and block counter = 0.
REQ-025 Reset mid-frame flushes in-flight bundles, which never appear at the output. The first valid after reset is block 0 regardless of in_sof.

Structure
REQ-026 Package fft_pkg holds LANES, FFT_N=512, TW_WIDTH, TW_FRAC=7 and the constant twiddle tables TW_R/TW_Q[512], computed per REQ-014.
REQ-027 One sub-module cmul_lane, a 3-stage pipelined complex multiply with round/saturate and a sat output, instantiated LANES times. The top holds the counter, ROM indexing and sideband pipeline.

Verification
REQ-028 Reset, then in_sof+in_valid, all lanes (100,-50) -> 3 cycles later out_valid=1, out_sof=1, out_blk=0, all lanes (100,-50) (twiddle 1).
REQ-029 Stream 13 consecutive bundles from sof, block 12 lane 0 = (100,0) -> block 12 lane 0 output (0,-100) (e=128, twiddle -j).
REQ-030 Block 10 lane 0 = (511,511) (e=64, twiddle (91,-91)) -> output (511,0) and sat_flag=1. Then sat_clr pulse -> sat_flag=0.
REQ-031 Stream 33 valid bundles with in_valid gaps of 2 cycles -> out_blk sequence 0..31,0, and out_valid pattern equals the in_valid pattern delayed by 3.
REQ-032 Assert rst with 2 bundles in flight -> no out_valid afterwards. The next in_valid without in_sof -> out_blk=0.
REQ-033 in_sof high with in_valid low mid-frame at block 5 -> ignored; the next valid bundle has out_blk=5.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared constants and twiddle ROM contents for the 512-point FFT twiddle stage.
// The tables are built at elaboration time with integer (Q30) arithmetic so
// every tool produces bit-identical ROM contents.
package fft_pkg;

    localparam int LANES    = 16;
    localparam int BLOCKS   = 32;
    localparam int FFT_N    = 512;
    localparam int TW_WIDTH = 9;
    localparam int TW_FRAC  = 7;
    localparam int QUARTER  = FFT_N / 4;

    typedef logic [FFT_N-1:0][TW_WIDTH-1:0] tw_table_t;

    // pi in Q30
    localparam longint PI_Q30 = 64'sd3373259426;

    // round(2^TW_FRAC * sin(2*pi*k/FFT_N)) for k in 0..QUARTER (first quadrant)
    function automatic int sin_quarter(input int k);
        longint x;
        longint x2;
        longint term;
        longint acc;
        x    = (longint'(k) * PI_Q30 * 2) / FFT_N;
        x2   = (x * x) >>> 30;
        term = x;
        acc  = x;
        for (int i = 1; i <= 8; i++) begin
            term = -((term * x2) >>> 30) / ((2 * i) * (2 * i + 1));
            acc  = acc + term;
        end
        return int'((acc * (longint'(1) <<< TW_FRAC) + (longint'(1) <<< 29)) >>> 30);
    endfunction

    // Full-circle sine by quadrant symmetry; rounding is symmetric about zero
    function automatic int sin_full(input int m);
        if (m <= QUARTER)          return sin_quarter(m);
        else if (m <= 2 * QUARTER) return sin_quarter(2 * QUARTER - m);
        else if (m <= 3 * QUARTER) return -sin_quarter(m - 2 * QUARTER);
        else                       return -sin_quarter(FFT_N - m);
    endfunction

    // Real part: cos(2*pi*e/N); imaginary part: -sin(2*pi*e/N)
    function automatic tw_table_t gen_tw(input bit imag);
        tw_table_t t;
        for (int e = 0; e < FFT_N; e++) begin
            if (imag) t[e] = TW_WIDTH'(-sin_full(e));
            else      t[e] = TW_WIDTH'(sin_full((e + QUARTER) % FFT_N));
        end
        return t;
    endfunction

    localparam tw_table_t TW_R = gen_tw(1'b0);
    localparam tw_table_t TW_Q = gen_tw(1'b1);

endpackage

// File: rtl/cmul_lane.sv
// One lane of the twiddle multiplier: 3-stage pipelined complex multiply
// (a + jb) * (c + jd), rounded by the twiddle fraction and saturated.
module cmul_lane #(
    parameter int IN_WIDTH  = 10,
    parameter int OUT_WIDTH = 10,
    parameter int TW_WIDTH  = 9
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        valid_i,
    input  logic signed [IN_WIDTH-1:0]  a_i,
    input  logic signed [IN_WIDTH-1:0]  b_i,
    input  logic signed [TW_WIDTH-1:0]  c_i,
    input  logic signed [TW_WIDTH-1:0]  d_i,
    output logic signed [OUT_WIDTH-1:0] re_o,
    output logic signed [OUT_WIDTH-1:0] im_o,
    output logic                        sat_o
);

    localparam int PW = IN_WIDTH + TW_WIDTH;   // product width
    localparam int SW = PW + 2;                // sum + rounding headroom
    localparam logic signed [SW-1:0] RND  = SW'(1 << (fft_pkg::TW_FRAC - 1));
    localparam logic signed [SW-1:0] MAXV = SW'((1 << (OUT_WIDTH - 1)) - 1);
    localparam logic signed [SW-1:0] MINV = ~MAXV;

    logic                       v1_q, v2_q;
    logic signed [IN_WIDTH-1:0] a_q, b_q;
    logic signed [TW_WIDTH-1:0] c_q, d_q;
    logic signed [PW-1:0]       ac_q, bd_q, ad_q, bc_q;
    logic signed [SW-1:0]       re_s, im_s;
    logic                       ov_re, ov_im;
    logic signed [OUT_WIDTH-1:0] re_c, im_c;
    logic signed [OUT_WIDTH-1:0] re_q, im_q;

    function automatic logic signed [OUT_WIDTH-1:0] clip(input logic signed [SW-1:0] v);
        if (v > MAXV)      return MAXV[OUT_WIDTH-1:0];
        else if (v < MINV) return MINV[OUT_WIDTH-1:0];
        else               return v[OUT_WIDTH-1:0];
    endfunction

    // Stage valids; a reset drops every bundle in flight
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            v1_q <= 1'b0;
            v2_q <= 1'b0;
        end else begin
            v1_q <= valid_i;
            v2_q <= v1_q;
        end
    end

    // S1 operand capture and S2 partial products
    always_ff @(posedge clk) begin
        // NOTE: datapath registers are not reset; the valids above make stale contents harmless.
        if (valid_i) begin
            a_q <= a_i;
            b_q <= b_i;
            c_q <= c_i;
            d_q <= d_i;
        end
        if (v1_q) begin
            ac_q <= PW'(a_q) * PW'(c_q);
            bd_q <= PW'(b_q) * PW'(d_q);
            ad_q <= PW'(a_q) * PW'(d_q);
            bc_q <= PW'(b_q) * PW'(c_q);
        end
    end

    // Full-precision sums, round half up, arithmetic shift, saturate
    always_comb begin
        // NOTE: every comb output is assigned on every pass, so no latch can form.
        re_s  = (SW'(ac_q) - SW'(bd_q) + RND) >>> fft_pkg::TW_FRAC;
        im_s  = (SW'(ad_q) + SW'(bc_q) + RND) >>> fft_pkg::TW_FRAC;
        ov_re = (re_s > MAXV) || (re_s < MINV);
        ov_im = (im_s > MAXV) || (im_s < MINV);
        re_c  = clip(re_s);
        im_c  = clip(im_s);
    end

    // S3 result register; holds its value across gaps
    always_ff @(posedge clk) begin
        if (rst) begin
            re_q <= '0;
            im_q <= '0;
        end else if (v2_q) begin
            re_q <= re_c;
            im_q <= im_c;
        end
    end

    assign re_o  = re_q;
    assign im_o  = im_q;
    // Asserted in the cycle whose edge loads a saturated result into S3
    assign sat_o = v2_q & (ov_re | ov_im);

endmodule

// File: rtl/twiddle_mul_16bundle.sv
// Twiddle multiplier for a 16-lane, 32-bundle (512-point) FFT frame.
// Tracks the block index, looks up per-lane twiddles and carries the
// sof/block sideband alongside the lanes' 3-stage pipeline.
module twiddle_mul_16bundle #(
    parameter int IN_WIDTH  = 10,
    parameter int OUT_WIDTH = 10,
    parameter int TW_WIDTH  = fft_pkg::TW_WIDTH,
    parameter int LANES     = fft_pkg::LANES,
    parameter int BLOCKS    = fft_pkg::BLOCKS
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               in_valid,
    input  logic                               in_sof,
    input  logic [LANES-1:0][IN_WIDTH-1:0]     din_R,
    input  logic [LANES-1:0][IN_WIDTH-1:0]     din_Q,
    input  logic                               sat_clr,
    output logic                               out_valid,
    output logic                               out_sof,
    output logic [$clog2(BLOCKS)-1:0]          out_blk,
    output logic [LANES-1:0][OUT_WIDTH-1:0]    dout_R,
    output logic [LANES-1:0][OUT_WIDTH-1:0]    dout_Q,
    output logic                               sat_flag
);

    import fft_pkg::TW_R;
    import fft_pkg::TW_Q;

    localparam int BW = $clog2(BLOCKS);
    localparam int LB = $clog2(LANES);
    localparam int NW = BW + LB;   // sample index width; BLOCKS*LANES is the frame size

    logic [BW-1:0]    blk_q, blk_d, cur_blk;
    logic             v1_q, v2_q, v3_q;
    logic             s1_q, s2_q, s3_q;
    logic [BW-1:0]    b1_q, b2_q, b3_q;
    logic             sat_q, sat_d;
    logic [LANES-1:0] lane_sat;

    // Block index for the bundle at the input and the counter's next value
    always_comb begin
        cur_blk = in_sof ? '0 : blk_q;
        blk_d   = blk_q;
        if (in_valid) blk_d = (cur_blk == BW'(BLOCKS - 1)) ? '0 : cur_blk + 1'b1;
        sat_d   = (|lane_sat) | (sat_q & ~sat_clr);
    end

    // Counter, sticky saturation flag and sideband pipeline
    always_ff @(posedge clk) begin
        if (rst) begin
            blk_q <= '0;
            sat_q <= 1'b0;
            v1_q  <= 1'b0;
            v2_q  <= 1'b0;
            v3_q  <= 1'b0;
            s1_q  <= 1'b0;
            s2_q  <= 1'b0;
            s3_q  <= 1'b0;
            b1_q  <= '0;
            b2_q  <= '0;
            b3_q  <= '0;
        end else begin
            blk_q <= blk_d;
            sat_q <= sat_d;
            v1_q  <= in_valid;
            v2_q  <= v1_q;
            v3_q  <= v2_q;
            s1_q  <= in_valid & in_sof;
            s2_q  <= s1_q;
            s3_q  <= v2_q & s2_q;
            if (in_valid) b1_q <= cur_blk;
            if (v1_q)     b2_q <= b1_q;
            if (v2_q)     b3_q <= b2_q;
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [NW-1:0] n;
        logic [1:0]    qmul;
        logic [NW-1:0] e;

        // n = blk*LANES + lane; quarter multiplier {0,2,1,3} is the bit-reversed quarter
        assign n    = {cur_blk, LB'(l)};
        assign qmul = {n[NW-2], n[NW-1]};
        assign e    = NW'(n[NW-3:0]) * NW'(qmul);

        cmul_lane #(
            .IN_WIDTH (IN_WIDTH),
            .OUT_WIDTH(OUT_WIDTH),
            .TW_WIDTH (TW_WIDTH)
        ) u_lane (
            .clk    (clk),
            .rst    (rst),
            .valid_i(in_valid),
            .a_i    ($signed(din_R[l])),
            .b_i    ($signed(din_Q[l])),
            .c_i    ($signed(TW_WIDTH'(TW_R[e]))),
            .d_i    ($signed(TW_WIDTH'(TW_Q[e]))),
            .re_o   (dout_R[l]),
            .im_o   (dout_Q[l]),
            .sat_o  (lane_sat[l])
        );
    end

    assign out_valid = v3_q;
    assign out_sof   = s3_q;
    assign out_blk   = b3_q;
    assign sat_flag  = sat_q;

endmodule
